// File: rtl/if_dual_fetch_pkg.sv
`default_nettype none
// ============================================================================
// if_dual_fetch_pkg : shared widths, stall encoding and IF state encoding
// Revision: 1.0
// ============================================================================
package if_dual_fetch_pkg;

   localparam int STALL_WD    = 6;
   localparam int IF_TO_ID_WD = 33;
   localparam int BR_WD       = 33;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFBF_FFF8;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HOLD      = 2'd1,
      HOLD_PEND = 2'd2
   } if_state_e;

   function automatic logic is_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_dual_fetch_if.sv
`default_nettype none
// ============================================================================
// if_dual_fetch_if : control inputs, IF->ID bus and inst SRAM port of IF
// Revision: 1.0
// ============================================================================
interface if_dual_fetch_if;
   import if_dual_fetch_pkg::*;

   logic                   flush;
   logic [31:0]            new_pc;
   logic [STALL_WD-1:0]    stall;
   logic                   fifo_full;
   logic [BR_WD-1:0]       br_bus;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;
   logic                   excp_adel;

   modport master (
      input  flush, new_pc, stall, fifo_full, br_bus,
      output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
             inst_sram_wdata, excp_adel
   );

   modport slave (
      output flush, new_pc, stall, fifo_full, br_bus,
      input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
             inst_sram_wdata, excp_adel
   );

endinterface
`default_nettype wire

// File: rtl/if_dual_fetch_pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// pc_redirect_buf : remembers a branch target resolved while IF is held
// Revision: 1.0
// ============================================================================
module pc_redirect_buf (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        latch_i,
   input  wire logic        clear_i,
   input  wire logic [31:0] addr_i,
   output logic             pend_v_o,
   output logic [31:0]      pend_addr_o
);

   logic        pend_v_q;
   logic [31:0] pend_addr_q;

   // A newer branch during the same hold overwrites the older target.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q    <= 1'b0;
         pend_addr_q <= 32'h0;
      end else if (clear_i) begin
         pend_v_q    <= 1'b0;
      end else if (latch_i) begin
         pend_v_q    <= 1'b1;
         pend_addr_q <= addr_i;
      end
   end

   assign pend_v_o    = pend_v_q;
   assign pend_addr_o = pend_addr_q;

endmodule
`default_nettype wire

// File: rtl/if_dual_fetch.sv
`default_nettype none
// ============================================================================
// if_dual_fetch : dual-issue IF stage, owns the PC and the 64-bit SRAM fetch
// Revision: 1.0
// ============================================================================
module if_dual_fetch
   import if_dual_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int          FETCH_BYTES = 8
) (
   input  wire logic        clk,
   input  wire logic        rst,
   if_dual_fetch_if.master  fetch_if
);

   localparam logic [31:0] C_FETCH_INC = 32'(FETCH_BYTES);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;

   logic        w_hold;
   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic        w_pend_v;
   logic [31:0] w_pend_addr;
   logic        w_adel;
   logic        w_ce_out;

   assign w_hold    = (fetch_if.stall[0] == STOP) | fetch_if.fifo_full;
   assign w_br_e    = fetch_if.br_bus[32];
   assign w_br_addr = fetch_if.br_bus[31:0];

   // Any unheld edge either consumes the pending target or is overridden by a live branch.
   pc_redirect_buf u_redirect_buf (
      .clk         (clk),
      .rst         (rst),
      .latch_i     (w_hold & w_br_e & ~fetch_if.flush),
      .clear_i     (fetch_if.flush | ~w_hold),
      .addr_i      (w_br_addr),
      .pend_v_o    (w_pend_v),
      .pend_addr_o (w_pend_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ce_q    <= ce_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ce_d    = ce_q;
      if (fetch_if.flush) begin
         pc_d    = fetch_if.new_pc;
         ce_d    = 1'b1;
         state_d = RUN;
      end else if (w_hold) begin
         if (w_br_e) begin
            state_d = HOLD_PEND;
         end else if (state_q != HOLD_PEND) begin
            state_d = HOLD;
         end
      end else if (w_br_e) begin
         pc_d    = w_br_addr;
         ce_d    = 1'b1;
         state_d = RUN;
      end else if (w_pend_v) begin
         pc_d    = w_pend_addr;
         ce_d    = 1'b1;
         state_d = RUN;
      end else begin
         pc_d    = pc_q + C_FETCH_INC;
         ce_d    = 1'b1;
         state_d = RUN;
      end
   end

   assign w_adel   = is_misaligned(pc_q[1:0]);
   assign w_ce_out = ce_q & ~w_adel;

   assign fetch_if.excp_adel       = w_adel;
   assign fetch_if.inst_sram_en    = w_ce_out;
   assign fetch_if.inst_sram_wen   = 4'b0000;
   assign fetch_if.inst_sram_addr  = pc_q;
   assign fetch_if.inst_sram_wdata = 32'h0;
   assign fetch_if.if_to_id_bus    = {w_ce_out, pc_q};

endmodule
`default_nettype wire

// File: doc/if_dual_fetch.md
Name:
if_dual_fetch

Overview:
Instruction-fetch stage of the dual-issue MIPS pipeline; directly upstream of ID.
- Owns the PC register.
- Issues one 64-bit read per cycle to inst SRAM, returning words at pc and pc+4.
- Drives if_to_id_bus {ce, pc}; ID pairs this bus with the returned SRAM data.
- Applies flush redirects, branch redirects from ID, and holds for stall or full instruction buffer.
- Keeps a pending-redirect register so a branch resolved during a hold is not lost.

Parameters:
RESET_PC, 32'hBFBF_FFF8, PC value held during reset; the first fetch is RESET_PC+8 = 32'hBFC0_0000.
FETCH_BYTES, 8, PC increment per sequential fetch (two instructions).

Ports:
clk  in  1  system clock; every register updates on its rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  exception/eret redirect strobe.
new_pc  in  32  redirect target; valid when flush=1.
stall  in  StallBus  pipeline stall vector; bit 0 = IF; Stop=1, NoStop=0.
fifo_full  in  1  ID instruction buffer full; treated as a hold.
br_bus  in  33  {br_e, br_addr[31:0]} from ID.
if_to_id_bus  out  IF_TO_ID_WD(33)  {ce, pc}.
inst_sram_en  out  1  read enable.
inst_sram_wen  out  4  always 4'b0.
inst_sram_addr  out  32  fetch address.
inst_sram_wdata  out  32  always 0.
excp_adel  out  1  current pc is misaligned (pc[1:0] != 0).

Behaviour:
- Registers: pc_r[31:0], ce_r, pend_v, pend_addr[31:0], state_r.
- Reset (rst=1 at an edge):
  - pc_r=RESET_PC, ce_r=0, pend_v=0, state=RUN.
  - All outputs low except pc field = RESET_PC; inst_sram_en=0.
- Outputs are registered-derived:
  - inst_sram_addr = pc_r; inst_sram_en = ce_r & ~excp_adel.
  - if_to_id_bus = {ce_r & ~excp_adel, pc_r}.
  - SRAM has one-cycle read latency: data for pc_r appears the cycle ID holds that pc.
- hold = (stall[0]==Stop) | fifo_full.
- next-pc priority, evaluated each edge when rst=0:
  1. flush: pc_r<=new_pc; ce_r<=1; pend_v<=0; state<=RUN. Flush overrides hold and br_e.
  2. hold: pc_r unchanged; ce_r unchanged. If br_e=1, then pend_v<=1 and pend_addr<=br_addr; state<=HOLD_PEND, otherwise state<=HOLD (or stays HOLD_PEND).
  3. br_e=1, not held: pc_r<=br_addr; pend_v<=0. A live branch wins over a pending one.
  4. pend_v=1, not held: pc_r<=pend_addr; pend_v<=0; state<=RUN.
  5. otherwise: pc_r<=pc_r+FETCH_BYTES, wrapping modulo 2^32; ce_r<=1.
- States:
  - RUN: normal sequential fetch.
  - HOLD: stalled, no redirect pending.
  - HOLD_PEND: stalled, redirect pending.
  - Transitions: RUN/HOLD -> HOLD_PEND on br_e while held; HOLD_PEND -> RUN on the first unheld edge; any state -> RUN on flush or rst.
- Boundary conditions:
  - Misaligned pc: excp_adel=1 combinationally, ce suppressed, and pc still advances per the rules above. The AdEL exception is raised downstream.
  - Reset asserted mid-hold: pending redirect discarded.
  - fifo_full together with stall[0]=NoStop holds exactly like a stall.

Decomposition:
- Shared defines (lib/defines.vh): StallBus, Stop/NoStop, IF_TO_ID_WD=33, BR_WD=33, RESET_PC value, IF state encodings RUN=2'd0, HOLD=2'd1, HOLD_PEND=2'd2.
- Sub-module pc_redirect_buf owns pend_v/pend_addr: latch on br_e&hold, clear on apply/flush/rst.
- The next-pc mux and outputs stay in if_dual_fetch.

Test Plan:
- Reset: rst high 3 cycles, then low -> the cycle after release has pc=32'hBFC0_0000 and ce=1. Subsequent cycles give 32'hBFC0_0008 and 32'hBFC0_0010; inst_sram_wen=0.
- Branch unstalled: at pc=32'hBFC0_0010 drive br_e=1, br_addr=32'hBFC0_0100 for one cycle -> next pc=32'hBFC0_0100, then 32'hBFC0_0108.
- Branch during stall: stall[0]=1 for 3 cycles, with br_e=1 and br_addr=32'hBFC0_0200 in the first stalled cycle only -> pc frozen for all 3 cycles, state=HOLD_PEND. On the first unstalled edge pc=32'hBFC0_0200 and pend_v=0.
- Flush priority: flush=1, new_pc=32'hBFC0_0380 in the same cycle as stall[0]=1 and br_e=1 -> pc=32'hBFC0_0380, pend_v=0, ce=1.
- fifo_full hold: fifo_full=1 for 2 cycles at pc=32'hBFC0_0040 -> pc holds at 32'hBFC0_0040 with inst_sram_en=1; advances to 32'hBFC0_0048 after release.
- Misaligned redirect: br_addr=32'hBFC0_0102 -> excp_adel=1, inst_sram_en=0, ce field=0. A following flush to 32'hBFC0_0380 clears excp_adel.
